// File: rtl/mem_access_if.sv
// Byte-wide RAM port shared with other masters through a req/gnt arbiter.
interface mem_access_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din;

    modport master (
        output mem_req,
        output mem_a,
        output mem_wr,
        output mem_dout,
        input  mem_gnt,
        input  mem_din
    );

    modport slave (
        input  mem_req,
        input  mem_a,
        input  mem_wr,
        input  mem_dout,
        output mem_gnt,
        output mem_din
    );
endinterface

// File: rtl/mem_access.sv
// MEM stage: passes ALU results through to mem_wb, and runs loads/stores as
// little-endian byte-serial transfers on an arbitrated 8-bit RAM port,
// stalling the pipeline until each access completes.
module mem_access #(
    parameter int unsigned      ADDR_W  = 32,
    parameter int unsigned      DATA_W  = 32,
    parameter int unsigned      OPT_W   = 6,
    parameter logic [OPT_W-1:0] OPT_LB  = OPT_W'(6'h20),
    parameter logic [OPT_W-1:0] OPT_LH  = OPT_W'(6'h21),
    parameter logic [OPT_W-1:0] OPT_LW  = OPT_W'(6'h23),
    parameter logic [OPT_W-1:0] OPT_LBU = OPT_W'(6'h24),
    parameter logic [OPT_W-1:0] OPT_LHU = OPT_W'(6'h25),
    parameter logic [OPT_W-1:0] OPT_SB  = OPT_W'(6'h28),
    parameter logic [OPT_W-1:0] OPT_SH  = OPT_W'(6'h29),
    parameter logic [OPT_W-1:0] OPT_SW  = OPT_W'(6'h2B)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPT_W-1:0]  opt_i,
    input  logic              we_i,
    input  logic [4:0]        waddr_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] rdata2_i,
    output logic              we_o,
    output logic [4:0]        waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stall_o,
    mem_access_if.master      mem
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        LAST,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         cnt;
    logic               rd_pend;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  sdata;
    logic [OPT_W-1:0]   opt_q;
    logic [4:0]         waddr_q;
    logic               we_q;
    logic [31:0]        lbuf;

    logic               in_is_mem;
    logic [2:0]         n_q;
    logic               st_q;
    logic [1:0]         cap_idx;

    function automatic logic [2:0] nbytes(input logic [OPT_W-1:0] op);
        if (op == OPT_LB || op == OPT_LBU || op == OPT_SB)
            return 3'd1;
        else if (op == OPT_LH || op == OPT_LHU || op == OPT_SH)
            return 3'd2;
        else if (op == OPT_LW || op == OPT_SW)
            return 3'd4;
        else
            return 3'd0;
    endfunction

    function automatic logic is_store(input logic [OPT_W-1:0] op);
        return (op == OPT_SB) || (op == OPT_SH) || (op == OPT_SW);
    endfunction

    // Operation decode for the incoming and the latched operation.
    always_comb begin
        in_is_mem = (nbytes(opt_i) != 3'd0);
        n_q       = nbytes(opt_q);
        st_q      = is_store(opt_q);
        // cnt has already advanced past the byte whose read data is arriving
        cap_idx   = 2'(cnt - 3'd1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and all outputs; reset forces every output low.
    always_comb begin
        state_nxt    = state;
        we_o         = 1'b0;
        waddr_o      = '0;
        wdata_o      = '0;
        stall_o      = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_a    = '0;
        mem.mem_wr   = 1'b0;
        mem.mem_dout = '0;
        case (state)
            IDLE: begin
                if (in_is_mem) begin
                    stall_o   = 1'b1;
                    state_nxt = REQ;
                end else begin
                    we_o    = we_i;
                    waddr_o = waddr_i;
                    wdata_o = alu_i;
                end
            end
            REQ: begin
                stall_o     = 1'b1;
                mem.mem_req = 1'b1;
                if (mem.mem_gnt)
                    state_nxt = XFER;
            end
            XFER: begin
                stall_o      = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_a    = addr + ADDR_W'(cnt);
                mem.mem_dout = sdata[{cnt[1:0], 3'b000} +: 8];
                if (mem.mem_gnt) begin
                    mem.mem_wr = st_q;
                    if (cnt == n_q - 3'd1)
                        state_nxt = st_q ? DONE : LAST;
                end
            end
            LAST: begin
                // Final byte arrives here; if it was never issued, the last
                // address is re-presented until grant lets it go out.
                stall_o     = 1'b1;
                mem.mem_req = 1'b1;
                mem.mem_a   = addr + ADDR_W'(cnt - 3'd1);
                if (rd_pend)
                    state_nxt = DONE;
            end
            DONE: begin
                waddr_o = waddr_q;
                if (!st_q) begin
                    we_o = we_q;
                    if (opt_q == OPT_LB)
                        wdata_o = {{(DATA_W-8){lbuf[7]}}, lbuf[7:0]};
                    else if (opt_q == OPT_LBU)
                        wdata_o = {{(DATA_W-8){1'b0}}, lbuf[7:0]};
                    else if (opt_q == OPT_LH)
                        wdata_o = {{(DATA_W-16){lbuf[15]}}, lbuf[15:0]};
                    else if (opt_q == OPT_LHU)
                        wdata_o = {{(DATA_W-16){1'b0}}, lbuf[15:0]};
                    else
                        wdata_o = DATA_W'(lbuf);
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            we_o         = 1'b0;
            waddr_o      = '0;
            wdata_o      = '0;
            stall_o      = 1'b0;
            mem.mem_req  = 1'b0;
            mem.mem_a    = '0;
            mem.mem_wr   = 1'b0;
            mem.mem_dout = '0;
        end
    end

    // Operand latch, byte counter, read-pending flag and load assembly buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            rd_pend <= 1'b0;
            addr    <= '0;
            sdata   <= '0;
            opt_q   <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            lbuf    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_is_mem) begin
                        addr    <= ADDR_W'(alu_i);
                        sdata   <= rdata2_i;
                        opt_q   <= opt_i;
                        waddr_q <= waddr_i;
                        we_q    <= we_i;
                        lbuf    <= '0;
                        cnt     <= '0;
                        rd_pend <= 1'b0;
                    end
                end
                REQ: begin
                    cnt     <= '0;
                    rd_pend <= 1'b0;
                end
                XFER: begin
                    if (rd_pend)
                        lbuf[{cap_idx, 3'b000} +: 8] <= mem.mem_din;
                    if (mem.mem_gnt) begin
                        cnt     <= cnt + 3'd1;
                        rd_pend <= ~st_q;
                    end else begin
                        rd_pend <= 1'b0;
                    end
                end
                LAST: begin
                    if (rd_pend) begin
                        lbuf[{cap_idx, 3'b000} +: 8] <= mem.mem_din;
                        rd_pend <= 1'b0;
                    end else if (mem.mem_gnt) begin
                        rd_pend <= 1'b1;
                    end
                end
                DONE: begin
                    cnt     <= '0;
                    rd_pend <= 1'b0;
                end
                default: begin
                    cnt     <= '0;
                    rd_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomised bench for mem_access: a synchronous byte RAM and a scripted
// arbiter drive the port; a reference memory predicts load data, store bytes
// and completion cycles from the operation rules.
`timescale 1ns/1ps
module tb_mem_access;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LB   = 6'h20;
    localparam logic [5:0] OP_LH   = 6'h21;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_LBU  = 6'h24;
    localparam logic [5:0] OP_LHU  = 6'h25;
    localparam logic [5:0] OP_SB   = 6'h28;
    localparam logic [5:0] OP_SH   = 6'h29;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  opt_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] alu_i;
    logic [31:0] rdata2_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [39:0] wr_log  [$];
    logic [5:0]  op_table [10];

    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(32)) bus ();

    mem_access #(
        .ADDR_W(32), .DATA_W(32), .OPT_W(6),
        .OPT_LB(OP_LB), .OPT_LH(OP_LH), .OPT_LW(OP_LW),
        .OPT_LBU(OP_LBU), .OPT_LHU(OP_LHU),
        .OPT_SB(OP_SB), .OPT_SH(OP_SH), .OPT_SW(OP_SW)
    ) dut (
        .clk(clk), .rst(rst), .opt_i(opt_i), .we_i(we_i), .waddr_i(waddr_i),
        .alu_i(alu_i), .rdata2_i(rdata2_i), .we_o(we_o), .waddr_o(waddr_o),
        .wdata_o(wdata_o), .stall_o(stall_o), .mem(bus)
    );

    function automatic logic [7:0] fill_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : fill_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill_byte(a);
    endfunction

    // Synchronous RAM: read byte appears the cycle after its address.
    always @(posedge clk) begin
        bus.mem_din <= ram_rd(bus.mem_a);
        if (bus.mem_wr === 1'b1) begin
            ram[bus.mem_a] = bus.mem_dout;
            wr_log.push_back({bus.mem_a, bus.mem_dout});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit is_st(input logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [31:0] load_value(input logic [5:0] op, input logic [31:0] a);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < nbytes_of(op); i++)
            w = w + (32'(ref_rd(a + 32'(i))) << (8 * i));
        if (op == OP_LB && w >= 32'd128)
            return w + 32'hFFFF_FF00;
        if (op == OP_LH && w >= 32'd32768)
            return w + 32'hFFFF_0000;
        return w;
    endfunction

    function automatic logic gnt_at(input int c, input int gwait, input logic [63:0] drops);
        if (c < 1 + gwait)
            return 1'b0;
        if (c < 64 && drops[c])
            return 1'b0;
        return 1'b1;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]     = b;
        ref_mem[a] = b;
    endtask

    // One operation from ex_mem: cycle 0 is the IDLE cycle presenting it.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic wen, input logic [4:0] wa, input int gwait,
                          input logic [63:0] drops);
        int          n;
        bit          st;
        int          g;
        int          k;
        int          issued;
        int          done_cyc;
        logic [31:0] exp_wd;
        logic        exp_we;
        logic        held_ok;
        logic [39:0] exp_log [$];
        n  = nbytes_of(op);
        st = is_st(op);
        wr_log.delete();
        @(posedge clk);
        #1;
        rst = 1'b1; opt_i = op; alu_i = a; rdata2_i = d; we_i = wen; waddr_i = wa;
        bus.mem_gnt = gnt_at(0, gwait, drops);
        if (n == 0) begin
            @(negedge clk);
            chk("pass_through", {we_o, waddr_o, wdata_o, stall_o, bus.mem_req},
                {wen, wa, a, 1'b0, 1'b0});
            return;
        end
        g = 1;
        while (!gnt_at(g, gwait, drops)) g++;
        k = g + 1;
        issued = 0;
        while (issued < n) begin
            if (gnt_at(k, gwait, drops)) issued++;
            k++;
        end
        done_cyc = k - 1 + (st ? 1 : 2);
        if (st) begin
            for (int i = 0; i < n; i++) begin
                exp_log.push_back({a + 32'(i), d[8*i +: 8]});
                ref_mem[a + 32'(i)] = d[8*i +: 8];
            end
            exp_we = 1'b0;
            exp_wd = 32'd0;
        end else begin
            exp_we = wen;
            exp_wd = load_value(op, a);
        end
        held_ok = 1'b1;
        for (int c = 0; c <= done_cyc; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                bus.mem_gnt = gnt_at(c, gwait, drops);
            end
            @(negedge clk);
            if (c < done_cyc)
                if (stall_o !== 1'b1 || bus.mem_req !== (c > 0) || we_o !== 1'b0)
                    held_ok = 1'b0;
        end
        chk("stall_held", held_ok, 1'b1);
        chk("done_stall_req", {stall_o, bus.mem_req}, 2'b00);
        chk("done_we", we_o, exp_we);
        chk("done_waddr", waddr_o, wa);
        chk("done_wdata", wdata_o, exp_wd);
        chk("write_count", wr_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++)
            chk("write_byte", wr_log[i], exp_log[i]);
    endtask

    initial begin
        op_table = '{OP_NOP, OP_ADDI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        opt_i = OP_NOP; we_i = 1'b1; waddr_i = 5'd3; alu_i = 32'h55; rdata2_i = 32'd0;
        bus.mem_gnt = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_wb", {we_o, waddr_o, wdata_o, stall_o}, 0);
        chk("reset_bus", {bus.mem_req, bus.mem_wr, bus.mem_a, bus.mem_dout}, 0);

        preload(32'h20, 8'h80);
        preload(32'h40, 8'h34);
        preload(32'h41, 8'h92);

        run_op(OP_ADDI, 32'h0000_0123, 32'd0, 1'b1, 5'd5, 0, 64'd0);
        run_op(OP_SW, 32'h100, 32'hDEAD_BEEF, 1'b0, 5'd7, 0, 64'd0);
        run_op(OP_LB, 32'h20, 32'd0, 1'b1, 5'd8, 0, 64'd0);
        run_op(OP_LBU, 32'h20, 32'd0, 1'b1, 5'd9, 1, 64'd0);
        run_op(OP_LH, 32'h40, 32'd0, 1'b1, 5'd10, 0, 64'd0);
        run_op(OP_LW, 32'h100, 32'd0, 1'b1, 5'd11, 3, 64'd1 << 7);
        run_op(OP_SH, 32'hFFFF_FFFF, 32'h0000_A55A, 1'b1, 5'd2, 0, 64'd0);
        run_op(OP_LHU, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd4, 2, 64'd0);
        run_op(OP_LW, 32'hFFFF_FFFE, 32'd0, 1'b1, 5'd6, 0, 64'h0000_0000_0000_0050);

        // Reset pulsed in the middle of an LW transfer, then the held LW reissues.
        @(posedge clk);
        #1;
        opt_i = OP_LW; alu_i = 32'h100; we_i = 1'b1; waddr_i = 5'd12; bus.mem_gnt = 1'b0;
        @(posedge clk);
        #1;
        bus.mem_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_xfer_busy", {stall_o, bus.mem_req}, 2'b11);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_async_wb", {we_o, waddr_o, wdata_o, stall_o}, 0);
        chk("rst_async_bus", {bus.mem_req, bus.mem_wr, bus.mem_a, bus.mem_dout}, 0);
        repeat (2) @(posedge clk);
        run_op(OP_LW, 32'h100, 32'd0, 1'b1, 5'd12, 0, 64'd0);

        for (int i = 0; i < 60; i++) begin
            logic [5:0]  op;
            logic [31:0] a;
            logic [63:0] drops;
            op = op_table[$urandom_range(0, 9)];
            case ($urandom_range(0, 2))
                0:       a = 32'h100 + $urandom_range(0, 15);
                1:       a = 32'hFFFF_FFF8 + $urandom_range(0, 7);
                default: a = $urandom;
            endcase
            drops = {$urandom, $urandom} & {$urandom, $urandom};
            run_op(op, a, $urandom, 1'($urandom_range(0, 1)), 5'($urandom),
                   $urandom_range(0, 3), drops);
        end

        @(posedge clk);
        #1;
        opt_i = OP_NOP;
        bus.mem_gnt = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage consumer of the execute result held in ex_mem. Passes non-memory results through to mem_wb.
- Loads and stores run as byte-serial transfers on an 8-bit RAM port. The port is shared through an arbiter that uses a req/gnt handshake.
- Stalls the pipeline until each access completes.

Parameters:
ADDR_W, 32, byte address width (alu_i / mem_a)
DATA_W, 32, register data width
OPT_W, 6, width of opt_i; encodings per defines.v (OptLB..OptSW)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
opt_i  in  OPT_W  operation from ex_mem
we_i  in  1  register write enable from ex_mem
waddr_i  in  5  destination register
alu_i  in  DATA_W  ALU result / effective address
rdata2_i  in  DATA_W  store data
we_o  out  1  write enable to mem_wb
waddr_o  out  5  destination register to mem_wb
wdata_o  out  DATA_W  writeback data to mem_wb
stall_o  out  1  hold ex_mem and earlier stages
mem_req  out  1  request RAM port from arbiter
mem_gnt  in  1  arbiter grant
mem_a  out  ADDR_W  RAM byte address
mem_wr  out  1  1=write, 0=read
mem_dout  out  8  RAM write byte
mem_din  in  8  RAM read byte, valid 1 cycle after address

Behaviour:
- Reset (rst=0, async): state IDLE; cnt=0; rd_pend=0; all outputs 0, including mem_wr. Reset mid-transfer aborts with no completion.
- Byte count N: 1 for LB/LBU/SB; 2 for LH/LHU/SH; 4 for LW/SW.
- Non-memory opt in IDLE is combinational pass-through: we_o=we_i, waddr_o=waddr_i, wdata_o=alu_i, stall_o=0, mem_req=0.
- IDLE, memory opt present:
  - stall_o=1.
  - Latch addr=alu_i, sdata=rdata2_i, opt, waddr; clear the load buffer.
  - Next state REQ.
- REQ: mem_req=1, stall_o=1. Go to XFER when mem_gnt=1, with cnt=0.
- XFER (mem_req=1, stall_o=1), each cycle with mem_gnt=1:
  - Drive mem_a=addr+cnt (mod 2^ADDR_W); mem_wr=is_store; mem_dout=sdata[8*cnt+7:8*cnt].
  - If load, set rd_pend=1.
  - If rd_pend was 1 last cycle, capture mem_din into byte cnt-1 of the buffer.
  - cnt++. At cnt==N-1: stores go to DONE, loads go to LAST.
- mem_gnt=0 in XFER:
  - Drive mem_wr=0; cnt holds.
  - A pending read byte is still captured this cycle; rd_pend then clears.
  - The arbiter must not drop grant mid-transfer, but the block tolerates it.
- LAST (loads only):
  - Capture the final byte from mem_din; mem_wr=0.
  - If mem_gnt was low on the final issue cycle, reissue that address when grant returns.
  - Then go to DONE.
- DONE (1 cycle): mem_req=0, stall_o=0, waddr_o=latched waddr.
  - Loads: we_o=1 (if we_i latched 1); wdata_o is the buffer, sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW.
  - Stores: we_o=0, wdata_o=0.
  - Next state IDLE. ex_mem advances on this edge, so no retrigger.
- Latency from grant: load N+2 cycles to DONE; store N+1 cycles to DONE.
- Byte order is little-endian. Misaligned addresses are legal (byte-serial), and address wrap past 0xFFFFFFFF goes to 0.

Test Plan:
- ADDI result 0x0000_0123, we_i=1, waddr 5 -> same cycle wdata_o=0x123, we_o=1, stall_o=0, mem_req=0.
- SW addr 0x100, data 0xDEADBEEF, gnt immediate -> mem_wr=1 for 4 consecutive cycles on 0x100..0x103 with bytes EF,BE,AD,DE; stall_o high until DONE; we_o=0.
- LB addr 0x20, RAM byte 0x80 -> wdata_o=0xFFFFFF80; LBU same address -> 0x00000080; LH over bytes 0x34,0x92 -> 0xFFFF9234.
- LW with mem_gnt withheld 3 cycles, then dropped for 1 cycle after byte 1 -> correct word assembled, no byte duplicated or skipped, stall_o held throughout.
- SH at 0xFFFFFFFF -> bytes written at 0xFFFFFFFF then 0x00000000.
- rst pulsed low during XFER of an LW -> all outputs 0 immediately, mem_wr=0; after release, IDLE reissues the still-held LW from the start.
